// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer, grant holding
// while the winner keeps requesting, and an optional hold-time limit.
module rr_ring_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 preempt,
    output logic [N-1:0]         ptr
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_r;
    logic [N-1:0]    grant_r;
    logic            grant_valid_r;
    logic [IW-1:0]   grant_id_r;
    logic            preempt_r;
    logic [N-1:0]    ptr_r;
    logic [HW-1:0]   hold_cnt_r;

    logic [IW-1:0]   ptr_idx_s;
    logic            pick_found_s;
    logic [IW-1:0]   pick_id_s;
    logic [N-1:0]    pick_oh_s;
    logic            owner_req_s;
    logic            timeout_s;

    function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Circular search: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        ptr_idx_s    = onehot_to_idx(ptr_r);
        pick_found_s = 1'b0;
        pick_id_s    = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (!pick_found_s && req[i] && (i >= int'(ptr_idx_s))) begin
                pick_found_s = 1'b1;
                pick_id_s    = IW'(i);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!pick_found_s && req[i]) begin
                pick_found_s = 1'b1;
                pick_id_s    = IW'(i);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        pick_oh_s = {{(N-1){1'b0}}, 1'b1} << pick_id_s;
    end

    // Release and hold-limit conditions for the current owner.
    always_comb begin
        owner_req_s = req[grant_id_r];
        if ((MAX_HOLD != 0) && (hold_cnt_r == HOLD_MAX)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Arbitration state machine with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            grant_r       <= {N{1'b0}};
            grant_valid_r <= 1'b0;
            grant_id_r    <= {IW{1'b0}};
            preempt_r     <= 1'b0;
            ptr_r         <= {{(N-1){1'b0}}, 1'b1};
            hold_cnt_r    <= {HW{1'b0}};
        end else begin
            preempt_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        grant_r       <= pick_oh_s;
                        grant_id_r    <= pick_id_s;
                        grant_valid_r <= 1'b1;
                        hold_cnt_r    <= HW'(1);
                        state_r       <= BUSY;
                    end else begin
                        state_r       <= IDLE;
                    end
                end
                BUSY: begin
                    if (!owner_req_s || timeout_s) begin
                        grant_r       <= {N{1'b0}};
                        grant_valid_r <= 1'b0;
                        ptr_r         <= {grant_r[N-2:0], grant_r[N-1]};
                        preempt_r     <= owner_req_s;
                        state_r       <= IDLE;
                    end else if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_r    <= hold_cnt_r + HW'(1);
                    end else begin
                        hold_cnt_r    <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    grant_r       <= {N{1'b0}};
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;
    assign preempt     = preempt_r;
    assign ptr         = ptr_r;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Bench for rr_ring_arbiter: an unlimited-hold and a MAX_HOLD=8 instance share
// one request vector and are both compared against an index-based reference.
module tb_rr_ring_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] g0, p0, g8, p8;
    logic       v0, pe0, v8, pe8;
    logic [1:0] id0, id8;

    always #5 clk = ~clk;

    rr_ring_arbiter #(.N(4), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .grant(g0), .grant_valid(v0),
        .grant_id(id0), .preempt(pe0), .ptr(p0)
    );

    rr_ring_arbiter #(.N(4), .MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .req(req), .grant(g8), .grant_valid(v8),
        .grant_id(id8), .preempt(pe8), .ptr(p8)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: owner index (-1 = none), pointer index, consecutive grant cycles.
    int m_owner[2];
    int m_ptr[2];
    int m_run[2];
    int m_id[2];
    int m_pre[2];
    int m_max[2] = '{0, 8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_run[k]   = 0;
            m_id[k]    = 0;
            m_pre[k]   = 0;
        end
    endfunction

    function automatic void model_step(input int k, input logic [3:0] r);
        m_pre[k] = 0;
        if (m_owner[k] < 0) begin
            for (int off = 0; off < 4; off++) begin
                int idx;
                idx = (m_ptr[k] + off) % 4;
                if (m_owner[k] < 0 && r[idx]) begin
                    m_owner[k] = idx;
                    m_id[k]    = idx;
                    m_run[k]   = 1;
                end
            end
        end else if (!r[m_owner[k]]) begin
            m_ptr[k]   = (m_owner[k] + 1) % 4;
            m_owner[k] = -1;
        end else if (m_max[k] != 0 && m_run[k] >= m_max[k]) begin
            m_ptr[k]   = (m_owner[k] + 1) % 4;
            m_owner[k] = -1;
            m_pre[k]   = 1;
        end else begin
            m_run[k]++;
        end
    endfunction

    task automatic check_dut(input int k);
        logic [3:0] g, p;
        logic       v, pe;
        logic [1:0] id;
        logic [3:0] eg;
        if (k == 0) begin
            g = g0; p = p0; v = v0; pe = pe0; id = id0;
        end else begin
            g = g8; p = p8; v = v8; pe = pe8; id = id8;
        end
        eg = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
        check($sformatf("mh%0d.grant", m_max[k]), g, eg);
        check($sformatf("mh%0d.grant_valid", m_max[k]), v, (m_owner[k] >= 0) ? 1 : 0);
        check($sformatf("mh%0d.grant_id", m_max[k]), id, m_id[k]);
        check($sformatf("mh%0d.preempt", m_max[k]), pe, m_pre[k]);
        check($sformatf("mh%0d.ptr", m_max[k]), p, 4'b0001 << m_ptr[k]);
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(0, r);
        model_step(1, r);
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
    endtask

    // Called just after a falling edge; reset is pulsed well before the next rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int         grants;
        int         releases;
        int         n;
        logic [3:0] exp_g[5]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_ptr[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] r;

        // Asynchronous reset before any clock edge, all requests pending.
        rst = 1'b0;
        req = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst.grant", g0, 4'b0000);
        check("rst.valid", v0, 1'b0);
        check("rst.ptr", p0, 4'b0001);
        check("rst.preempt", pe8, 1'b0);
        check_dut(1);
        @(negedge clk);

        // Fairness: each winner drops its request after three grant cycles.
        do_reset();
        grants   = 0;
        releases = 0;
        for (int c = 0; c < 20; c++) begin
            int was;
            r = 4'b1111;
            if (m_owner[0] >= 0 && m_run[0] == 3) r[m_owner[0]] = 1'b0;
            was = m_owner[0];
            step(r);
            if (was < 0 && m_owner[0] >= 0 && grants < 5) begin
                check("fair.grant_seq", g0, exp_g[grants]);
                grants++;
            end
            if (was >= 0 && m_owner[0] < 0 && releases < 4) begin
                check("fair.ptr_seq", p0, exp_ptr[releases]);
                check("fair.dead_cycle", g0, 4'b0000);
                releases++;
            end
        end
        check("fair.grant_count", grants, 5);

        // Wrap search: pointer at index 2, only requesters 0 and 1 pending.
        do_reset();
        step(4'b0010);
        check("wrap.first", g0, 4'b0010);
        step(4'b0000);
        check("wrap.ptr", p0, 4'b0100);
        step(4'b0011);
        check("wrap.grant", g0, 4'b0001);
        check("wrap.id", id0, 2'd0);

        // Hold-limit timeout on the MAX_HOLD=8 instance.
        do_reset();
        step(4'b0101);
        n = (g8 == 4'b0001) ? 1 : 0;
        for (int c = 0; c < 12; c++) begin
            step(4'b0101);
            if (g8 == 4'b0001) n++;
            else break;
        end
        check("to.hold_len", n, 8);
        check("to.grant_off", g8, 4'b0000);
        check("to.preempt", pe8, 1'b1);
        step(4'b0101);
        check("to.next_grant", g8, 4'b0100);
        check("to.next_id", id8, 2'd2);
        check("to.next_ptr", p8, 4'b0010);
        check("to.preempt_pulse", pe8, 1'b0);

        // Reset pulse in the middle of a grant.
        do_reset();
        step(4'b0010);
        check("midrst.before", g0, 4'b0010);
        req = 4'b0010;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst.grant", g0, 4'b0000);
        check("midrst.ptr", p0, 4'b0001);
        check_dut(1);
        #1;
        rst = 1'b0;
        step(4'b0010);
        check("midrst.regrant", g0, 4'b0010);

        // Single requester at the top index.
        do_reset();
        step(4'b1000);
        check("single.grant", g8, 4'b1000);
        check("single.id", id8, 2'd3);
        step(4'b0000);
        check("single.release", g8, 4'b0000);
        check("single.ptr", p8, 4'b0001);

        // Random traffic with sticky request bits and occasional resets.
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            step(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
